// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage next-PC generator feeding the branch prediction unit.
// Owns the fetch PC, follows BPU predictions, and redirects on EXE mispredicts.
//
// Parameters: PC (PC width), RESET_PC (first fetch address), INC (sequential
// byte increment), CNT (performance counter width).
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   stall_in                  downstream stall, holds the fetch PC
//   prediction_in             BPU taken prediction for fetch_pc_out
//   pred_target_in            BPU predicted target for fetch_pc_out
//   exe_valid_in/branch_in    EXE holds a valid branch/jump
//   exe_taken_in              resolved direction
//   exe_pc_in/new_pc_in       EXE instruction PC and resolved target
//   exe_pred_next_in          next PC predicted at fetch for that instruction
//   fetch_pc_out/valid_out    registered fetch PC and its valid flag
//   fetch_pred_next_out       combinational predicted next PC
//   flush_out                 registered one-cycle pipeline flush
//   write_pc_out              registered one-cycle BPU training write
//   br_count_out              resolved branch count
//   mispred_count_out         mispredicted branch count
//
// Optional feature: define PC_GEN_PERF_EN to build saturating performance
// counters; otherwise both counter outputs are tied to zero.

module fetch_pc_gen #(
    parameter int unsigned     PC       = 32,
    parameter logic [PC-1:0]   RESET_PC = '0,
    parameter int unsigned     INC      = 4,
    parameter int unsigned     CNT      = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          stall_in,
    input  logic          prediction_in,
    input  logic [PC-1:0] pred_target_in,
    input  logic          exe_valid_in,
    input  logic          exe_branch_in,
    input  logic          exe_taken_in,
    input  logic [PC-1:0] exe_pc_in,
    input  logic [PC-1:0] exe_new_pc_in,
    input  logic [PC-1:0] exe_pred_next_in,
    output logic [PC-1:0] fetch_pc_out,
    output logic          fetch_valid_out,
    output logic [PC-1:0] fetch_pred_next_out,
    output logic          flush_out,
    output logic          write_pc_out,
    output logic [CNT-1:0] br_count_out,
    output logic [CNT-1:0] mispred_count_out
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PC-1:0] pc_q, pc_d;
    logic          valid_q, valid_d;
    logic          flush_q, flush_d;
    logic          write_q, write_d;

    logic          exe_is_branch;
    logic          pred_taken;
    logic [PC-1:0] pred_next;
    logic [PC-1:0] actual_next;
    logic          mispredict;

    // BPU inputs only mean something while a real fetch is presented.
    assign pred_taken = prediction_in & valid_q;
    assign pred_next  = pred_taken ? {pred_target_in[PC-1:2], 2'b00}
                                   : PC'(pc_q + PC'(INC));

    assign exe_is_branch = exe_valid_in & exe_branch_in;
    assign actual_next   = exe_taken_in ? exe_new_pc_in
                                        : PC'(exe_pc_in + PC'(INC));
    assign mispredict    = exe_is_branch & (actual_next != exe_pred_next_in);

    // Next-state and next-output logic; mispredict outranks stall and prediction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        write_d = 1'b0;

        if (mispredict) begin
            pc_d    = actual_next;
            valid_d = 1'b0;
            flush_d = 1'b1;
            state_d = ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end
                ST_RUN: begin
                    if (!stall_in) begin
                        pc_d = pred_next;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                    valid_d = 1'b0;
                end
            endcase
        end

        // Train on every resolved taken branch once out of BOOT.
        write_d = (state_q != ST_BOOT) & exe_is_branch & exe_taken_in;
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            write_q <= write_d;
        end
    end

    assign fetch_pc_out        = pc_q;
    assign fetch_valid_out     = valid_q;
    assign fetch_pred_next_out = pred_next;
    assign flush_out           = flush_q;
    assign write_pc_out        = write_q;

`ifdef PC_GEN_PERF_EN
    localparam logic [CNT-1:0] CNT_MAX = '1;

    logic [CNT-1:0] br_cnt_q, br_cnt_d;
    logic [CNT-1:0] mp_cnt_q, mp_cnt_d;

    // Saturating event counters.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (exe_is_branch && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = CNT'(br_cnt_q + CNT'(1));
        end
        if (mispredict && (mp_cnt_q != CNT_MAX)) begin
            mp_cnt_d = CNT'(mp_cnt_q + CNT'(1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_count_out      = br_cnt_q;
    assign mispred_count_out = mp_cnt_q;
`else
    assign br_count_out      = '0;
    assign mispred_count_out = '0;
`endif

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator sitting directly upstream of the branch prediction unit. It owns the fetch PC register, presents each fetch PC to the BPU, consumes the BPU's prediction and predicted target, and resolves mispredictions reported by EXE. It produces the flush pulse and the taken-branch training write the BPU consumes.

## Interface
- PC, 32, PC width in bits
- RESET_PC, 32'h0000_0000, first fetch address after reset
- INC, 4, sequential increment in bytes
- CNT, 32, width of performance counters

- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  reset, synchronous, active-high
- stall_in  in  1  fetch stall from downstream; holds PC
- prediction_in  in  1  BPU taken prediction for current fetch_pc_out
- pred_target_in  in  PC  BPU predicted target for current fetch_pc_out
- exe_valid_in  in  1  EXE holds a valid instruction
- exe_branch_in  in  1  EXE instruction is a branch/jump
- exe_taken_in  in  1  resolved direction
- exe_pc_in  in  PC  PC of EXE instruction
- exe_new_pc_in  in  PC  resolved target
- exe_pred_next_in  in  PC  next PC predicted at fetch, carried down pipeline
- fetch_pc_out  out  PC  current fetch PC (registered)
- fetch_valid_out  out  1  fetch_pc_out is a real fetch (registered)
- fetch_pred_next_out  out  PC  predicted next PC for current fetch (combinational)
- flush_out  out  1  one-cycle pipeline flush (registered)
- write_pc_out  out  1  one-cycle BPU training write (registered)
- br_count_out  out  CNT  resolved branches
- mispred_count_out  out  CNT  mispredicted branches

## Operation
- States: BOOT, RUN, FLUSH.
- Reset: state=BOOT, fetch_pc_out=RESET_PC, fetch_valid_out=0, flush_out=0, write_pc_out=0, counters=0.
- BOOT: one cycle; next state RUN, fetch_valid_out<=1, PC unchanged.
- fetch_pred_next_out = prediction_in ? {pred_target_in[PC-1:2],2'b00} : fetch_pc_out+INC (mod 2^PC).
- actual_next = exe_taken_in ? exe_new_pc_in : exe_pc_in+INC (mod 2^PC).
- mispredict = exe_valid_in & exe_branch_in & (actual_next != exe_pred_next_in).
- Priority each cycle: rst_in > mispredict > stall_in > prediction > sequential.
- Mispredict (any non-reset state): fetch_pc_out<=actual_next, fetch_valid_out<=0, flush_out<=1, state<=FLUSH. Overrides stall_in.
- FLUSH: one bubble; next state RUN, fetch_valid_out<=1, PC held. A further mispredict in FLUSH restarts FLUSH with new actual_next.
- RUN, no mispredict: stall_in=1 holds PC and valid; stall_in=0 loads fetch_pred_next_out.
- write_pc_out<=exe_valid_in & exe_branch_in & exe_taken_in, independent of stall and state (not BOOT).
- prediction_in/pred_target_in ignored while fetch_valid_out=0.

## Timing
- Cycle N mispredict at EXE -> N+1: flush_out=1, fetch_pc_out=actual_next, fetch_valid_out=0 -> N+2: fetch_valid_out=1, same PC. Penalty: one bubble plus flushed stages.
- Correct prediction: zero bubbles; taken target fetched the cycle after fetch_pc_out presented.
- flush_out and write_pc_out high exactly one cycle per event; back-to-back events give back-to-back pulses.
- rst_in asserted mid-FLUSH or mid-stall: next cycle all outputs at reset values.
- PC wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000, no fault.

## Configuration
- PC_GEN_PERF_EN defined: br_count_out increments on every exe_valid_in&exe_branch_in; mispred_count_out increments on every mispredict; both saturate at 2^CNT-1; cleared by rst_in; registered, visible next cycle.
- Undefined: no counter registers; both outputs tied to 0. Port list unchanged.

## Test plan
- Reset, RESET_PC=0x100, stall_in=0, prediction_in=0 -> cycle1 valid=0 pc=0x100; cycle2 valid=1 pc=0x100; cycle3 pc=0x104.
- prediction_in=1, pred_target_in=0x203 at pc=0x108 -> next pc=0x200, flush_out=0.
- EXE branch pc=0x40 taken target 0x80, exe_pred_next_in=0x44 -> next cycle flush_out=1, pc=0x80, valid=0, write_pc_out=1; following cycle valid=1.
- Mispredict with stall_in=1 same cycle -> redirect still taken; not-taken branch pc=0x40 with pred_next 0x80 -> pc=0x44, write_pc_out=0.
- pc=0xFFFF_FFFC, no prediction -> next pc=0x0; rst_in during FLUSH -> all outputs reset next cycle.
- With PC_GEN_PERF_EN, CNT=2: 5 mispredicts -> mispred_count_out=3, br_count_out=3; without macro both 0.
